seven_seg_mux_ctrl: RTL and testbench

//  Time-multiplexes one shared hex-to-seven-segment decoder across two common-anode digits.

---
 rtl/seven_seg_pkg.sv | 25 ++
 rtl/seven_seg_decoder.sv | 38 +++
 rtl/seven_seg_mux_ctrl.sv | 144 ++++++++++++++
 tb/tb_seven_seg_mux_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module : seven_seg_pkg
// Brief  : Shared types and constants for the two-digit seven-segment scanner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

  typedef enum logic [1:0] {
    BLANK_0 = 2'd0,
    SHOW_0  = 2'd1,
    BLANK_1 = 2'd2,
    SHOW_1  = 2'd3
  } mux_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic is_show(input mux_state_t s);
    return (s == SHOW_0) || (s == SHOW_1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_decoder.sv
// ============================================================================
// Module : seven_seg_decoder
// Brief  : Hex nibble to active-low seven-segment pattern {g..a}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_seg_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    case (hex)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_seg_mux_ctrl.sv
// ============================================================================
// Module : seven_seg_mux_ctrl
// Brief  : Two-digit common-anode scanner with blanking dead-time between
//          digits. Optional macro BRIGHTNESS_PWM_EN adds a duty[3:0] input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_seg_mux_ctrl #(
  parameter int SLOT_CYC  = 48_000,
  parameter int BLANK_CYC = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0] duty,
`endif
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  import seven_seg_pkg::*;

  localparam int CNT_W = $clog2(SLOT_CYC);
  localparam logic [CNT_W-1:0] c_SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] c_BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  generate
    if (BLANK_CYC < 2 || BLANK_CYC >= SLOT_CYC) begin : g_bad_params
      $error("seven_seg_mux_ctrl: BLANK_CYC must lie in 2 .. SLOT_CYC-1");
    end
  endgenerate

  mux_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       hex_q, hex_d;
  logic [6:0]       seg_q, seg_dec;
  logic [1:0]       an_q, an_d;
  logic             tick_q, tick_d;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]       pwm_q, pwm_d;
  logic [3:0]       duty_q, duty_d;
`endif

  seven_seg_decoder u_dec (
    .hex   (hex_q),
    .seg_n (seg_dec)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      BLANK_0: if (cnt_q == c_BLANK_LAST) state_d = SHOW_0;
      SHOW_0:  if (cnt_q == c_SLOT_LAST) begin
                 state_d = BLANK_1;
                 cnt_d   = '0;
               end
      BLANK_1: if (cnt_q == c_BLANK_LAST) state_d = SHOW_1;
      SHOW_1:  if (cnt_q == c_SLOT_LAST) begin
                 state_d = BLANK_0;
                 cnt_d   = '0;
               end
      default: begin
                 state_d = BLANK_0;
                 cnt_d   = '0;
               end
    endcase
    // Hold takes priority over any slot boundary in the same cycle.
    if (!en) begin
      state_d = BLANK_0;
      cnt_d   = '0;
    end
  end

  // Digit value is captured during the first blank cycle, leaving a full
  // cycle for the registered decode to settle before the anode turns on.
  always_comb begin
    hex_d = hex_q;
`ifdef BRIGHTNESS_PWM_EN
    duty_d = duty_q;
`endif
    if (!is_show(state_q) && cnt_q == '0) begin
      hex_d = (state_q == BLANK_1) ? s1 : s0;
`ifdef BRIGHTNESS_PWM_EN
      duty_d = duty;
`endif
    end
  end

`ifdef BRIGHTNESS_PWM_EN
  always_comb begin
    pwm_d = '0;
    if (is_show(state_d) && state_d == state_q) pwm_d = pwm_q + 1'b1;
  end
`endif

  always_comb begin
    an_d = 2'b11;
    if (state_d == SHOW_0)      an_d = 2'b10;
    else if (state_d == SHOW_1) an_d = 2'b01;
`ifdef BRIGHTNESS_PWM_EN
    if (pwm_d >= duty_q) an_d = 2'b11;
`endif
    tick_d = (state_d == SHOW_1) && (cnt_d == c_SLOT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BLANK_0;
      cnt_q   <= '0;
      hex_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= 2'b11;
      tick_q  <= 1'b0;
`ifdef BRIGHTNESS_PWM_EN
      pwm_q   <= '0;
      duty_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      seg_q   <= seg_dec;
      an_q    <= an_d;
      tick_q  <= tick_d;
`ifdef BRIGHTNESS_PWM_EN
      pwm_q   <= pwm_d;
      duty_q  <= duty_d;
`endif
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_mux_ctrl.sv
// ============================================================================
// Module : tb_seven_seg_mux_ctrl
// Brief  : Self-checking bench for seven_seg_mux_ctrl (also builds with
//          BRIGHTNESS_PWM_EN defined).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_mux_ctrl;

`ifdef BRIGHTNESS_PWM_EN
  localparam int SLOT = 40;
`else
  localparam int SLOT = 8;
`endif
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] s0, s1;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0] duty;
`endif

  always #5 clk = ~clk;

  seven_seg_mux_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .s0         (s0),
    .s1         (s1),
`ifdef BRIGHTNESS_PWM_EN
    .duty       (duty),
`endif
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: p is the position inside a 2*SLOT frame; each digit shows the
  // value seen at the first cycle of its slot.
  int         p = 0;
  logic [3:0] lat [2];
  logic [3:0] duty_lat;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p        <= 0;
      lat[0]   <= 4'h0;
      lat[1]   <= 4'h0;
      duty_lat <= 4'h0;
    end else begin
      if (p % SLOT == 0) begin
        lat[p / SLOT] <= (p == 0) ? s0 : s1;
`ifdef BRIGHTNESS_PWM_EN
        duty_lat <= duty;
`endif
      end
      p <= en ? (p + 1) % (2 * SLOT) : 0;
    end
  end

  function automatic logic [1:0] exp_an();
    int w = p % SLOT;
    if (w < BLANK) return 2'b11;
`ifdef BRIGHTNESS_PWM_EN
    if (((w - BLANK) % 16) >= int'(duty_lat)) return 2'b11;
`endif
    return (p < SLOT) ? 2'b10 : 2'b01;
  endfunction

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("an", an, exp_an());
      check("frame_tick", frame_tick, (p == 2 * SLOT - 1));
      check("an_overlap", (an == 2'b00), 1'b0);
      if (exp_an() != 2'b11) check("seg", seg, glyph[lat[p / SLOT]]);
    end
  end

  task automatic wait_tick();
    bit got = 1'b0;
    for (int i = 0; i < 4 * SLOT && !got; i++) begin
      @(negedge clk);
      #1;
      got = frame_tick;
    end
    check("tick_timeout", got, 1'b1);
  endtask

`ifdef BRIGHTNESS_PWM_EN
  task automatic pwm_case(input logic [3:0] d, input int ncyc, input int exp_cnt, input string nm);
    int act = 0;
    duty = d;
    wait_tick();
    repeat (2) @(negedge clk);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      #1;
      if (an == 2'b10) act++;
    end
    check(nm, act, exp_cnt);
  endtask
`endif

  initial begin
    int cnt;
    logic [1:0] pat [16];
    logic [1:0] exp_pat [16] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    reset = 1'b1; en = 1'b0; s0 = 4'h0; s1 = 4'h0;
`ifdef BRIGHTNESS_PWM_EN
    duty = 4'hF;
`endif
    #1;
    check("reset_an", an, 2'b11);
    check("reset_seg", seg, 7'h7F);
    check("reset_tick", frame_tick, 1'b0);
    repeat (2) @(negedge clk);
    s0 = 4'h8; s1 = 4'h1; en = 1'b1;
    reset = 1'b0;
    chk_on = 1'b1;

`ifndef BRIGHTNESS_PWM_EN
    // Reset pulse in the middle of SHOW_0, then the post-release anode sequence.
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_an", an, 2'b11);
    check("midreset_seg", seg, 7'h7F);
    @(negedge clk);
    reset = 1'b0;
    #1 pat[0] = an;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      #1 pat[i] = an;
    end
    for (int i = 0; i < 16; i++) check("post_reset_seq", pat[i], exp_pat[i]);

    // Steady 8 / 1 display.
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (an == 2'b10 && seg != 7'h00) cnt++;
      if (an == 2'b01 && seg != 7'h79) cnt++;
      if (an == 2'b00) cnt++;
    end
    check("digits_8_1", cnt, 0);

    // Mid-slot change of s0 is deferred to the next frame.
    s0 = 4'h3; s1 = 4'h5;
    wait_tick();
    repeat (5) @(negedge clk);
    #1;
    check("midslot_an", an, 2'b10);
    check("midslot_seg_before", seg, 7'h30);
    s0 = 4'hA;
    repeat (2) @(negedge clk);
    #1 check("midslot_seg_hold", seg, 7'h30);
    wait_tick();
    repeat (3) @(negedge clk);
    #1;
    check("nextframe_an", an, 2'b10);
    check("nextframe_seg", seg, 7'h08);

    // Frame tick rate.
    cnt = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      #1;
      if (frame_tick) cnt++;
    end
    check("tick_count", cnt, 10);

    // Enable dropped for 5 cycles during SHOW_1.
    wait_tick();
    repeat (12) @(negedge clk);
    #1 check("en_pre_an", an, 2'b01);
    en = 1'b0;
    @(negedge clk);
    #1 check("en_low_an", an, 2'b11);
    repeat (4) @(negedge clk);
    en = 1'b1;
    #1 check("en_resume_0", an, 2'b11);
    @(negedge clk);
    #1 check("en_resume_1", an, 2'b11);
    @(negedge clk);
    #1 check("en_resume_2", an, 2'b10);
`else
    pwm_case(4'd0, 38, 0, "pwm_duty0");
    pwm_case(4'd8, 16, 8, "pwm_duty8");
    pwm_case(4'd15, 16, 15, "pwm_duty15");
`endif

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(7) == 0) s0 = 4'($urandom);
      if ($urandom_range(7) == 0) s1 = 4'($urandom);
`ifdef BRIGHTNESS_PWM_EN
      if ($urandom_range(63) == 0) duty = 4'($urandom);
`endif
      en = ($urandom_range(59) != 0);
      if ($urandom_range(499) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end

    en = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
